// File: rtl/ifetch_pkg.sv
// Shared definitions for the fetch stage: opcodes, counter encodings and the
// saturating counter update used by the branch history table.
package ifetch_pkg;

  localparam logic [4:0] OP_B    = 5'b00010;
  localparam logic [4:0] OP_BEQZ = 5'b00100;
  localparam logic [4:0] OP_BNEZ = 5'b00101;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Move a 2-bit counter one step toward the resolved direction, saturating at both ends.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != ST) res = cnt + 2'd1;
    end else begin
      if (cnt != SNT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ifetch_bp_if.sv
// Fetch-stage bus: control from execute, the IMEM word, BHT update and the
// PC outputs. The fetch block is the slave; the pipeline around it is the master.
interface ifetch_bp_if #(parameter int PC_W = 16);

  logic            stall_i;
  logic            redirect_i;
  logic [PC_W-1:0] redirect_addr_i;
  logic            mispredict_i;
  logic [15:0]     instr_i;
  logic            upd_valid_i;
  logic [PC_W-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [PC_W-1:0] pc_o;
  logic [PC_W-1:0] pcplus1_o;
  logic            pred_taken_o;
  logic [PC_W-1:0] epc_o;

  modport slave (
    input  stall_i, redirect_i, redirect_addr_i, mispredict_i, instr_i,
           upd_valid_i, upd_pc_i, upd_taken_i,
    output pc_o, pcplus1_o, pred_taken_o, epc_o
  );

  modport master (
    output stall_i, redirect_i, redirect_addr_i, mispredict_i, instr_i,
           upd_valid_i, upd_pc_i, upd_taken_i,
    input  pc_o, pcplus1_o, pred_taken_o, epc_o
  );

endinterface

// File: rtl/ifetch_bp_bht.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port for the fetch PC and one clocked update port for resolved branches.
module bht_2bit
  import ifetch_pkg::*;
#(
  parameter int         IDX_W    = 8,
  parameter logic [1:0] CNT_INIT = WNT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_cnt,
  input  logic             i_upd_valid,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] r_cnt [DEPTH];

  // Read returns the stored value, so a same-cycle update is seen one cycle later.
  assign o_rd_cnt = r_cnt[i_rd_idx];

  // Reset every entry to the initial bias; otherwise nudge the addressed counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_cnt[i] <= CNT_INIT;
    end else if (i_upd_valid) begin
      r_cnt[i_upd_idx] <= sat_update(r_cnt[i_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/ifetch_bp.sv
// Fetch stage with branch prediction: holds the PC, decodes branch opcodes
// from the fetched word, predicts conditional branches from the BHT and
// selects the next PC, keeping the not-chosen path for mispredict recovery.
module ifetch_bp
  import ifetch_pkg::*;
#(
  parameter int         PC_W     = 16,
  parameter int         IDX_W    = 8,
  parameter logic [1:0] CNT_INIT = WNT
) (
  input  logic       CLK,
  input  logic       RST,
  ifetch_bp_if.slave bus
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pc_lock;
  logic [PC_W-1:0] r_alt_lock;
  logic            r_boot;

  logic [4:0]      w_op;
  logic            w_is_b;
  logic            w_is_cond;
  logic [PC_W-1:0] w_imm;
  logic [PC_W-1:0] w_seq;
  logic [PC_W-1:0] w_tgt;
  logic [PC_W-1:0] w_next;
  logic [1:0]      w_cnt;
  logic            w_pred;

  assign w_op      = bus.instr_i[15:11];
  assign w_is_b    = (w_op == OP_B);
  assign w_is_cond = (w_op == OP_BEQZ) || (w_op == OP_BNEZ);

  // Signed casts sign-extend (or wrap, for narrow PCs) the branch offset to PC width.
  assign w_imm = w_is_b ? PC_W'($signed(bus.instr_i[10:0]))
                        : PC_W'($signed(bus.instr_i[7:0]));
  assign w_seq = r_pc + PC_W'(1);
  assign w_tgt = w_seq + w_imm;

  bht_2bit #(
    .IDX_W   (IDX_W),
    .CNT_INIT(CNT_INIT)
  ) u_bht (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_rd_idx   (r_pc[IDX_W-1:0]),
    .o_rd_cnt   (w_cnt),
    .i_upd_valid(bus.upd_valid_i),
    .i_upd_idx  (bus.upd_pc_i[IDX_W-1:0]),
    .i_upd_taken(bus.upd_taken_i)
  );

  // Only the upper PC bits of the update port are ignored (aliasing is accepted).
  generate
    if (IDX_W < PC_W) begin : g_upd_hi
      logic w_unused;
      assign w_unused = ^bus.upd_pc_i[PC_W-1:IDX_W];
    end
  endgenerate

  assign w_pred = w_is_b | (w_is_cond & w_cnt[1]);

  // Execute-stage corrections win over the prediction; JR beats mispredict.
  assign w_next = bus.redirect_i   ? bus.redirect_addr_i :
                  bus.mispredict_i ? r_alt_lock          :
                  w_pred           ? w_tgt               : w_seq;

  // PC and lock registers; the first unstalled edge after reset is a bubble at PC 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc       <= '0;
      r_pc_lock  <= '0;
      r_alt_lock <= '0;
      r_boot     <= 1'b1;
    end else if (!bus.stall_i) begin
      if (r_boot) begin
        r_boot <= 1'b0;
      end else begin
        r_pc_lock  <= r_pc;
        r_alt_lock <= w_pred ? w_seq : w_tgt;
        r_pc       <= w_next;
      end
    end
  end

  assign bus.pc_o         = r_pc;
  assign bus.pcplus1_o    = w_seq;
  assign bus.pred_taken_o = w_pred;
  assign bus.epc_o        = (bus.redirect_i || bus.mispredict_i) ? r_pc_lock : r_pc;

endmodule

// File: tb/tb_ifetch_bp.sv
// Bench for ifetch_bp: two instances (16-bit PC / 256-entry BHT and 8-bit PC /
// 16-entry BHT) driven side by side, checked every cycle against a behavioural
// model, with directed scenarios pinned by literal expectations.
module tb_ifetch_bp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_bp_if #(.PC_W(16)) if16 ();
  ifetch_bp_if #(.PC_W(8))  if8 ();

  ifetch_bp #(.PC_W(16), .IDX_W(8), .CNT_INIT(2'b01)) u_dut16 (.CLK(clk), .RST(rst), .bus(if16));
  ifetch_bp #(.PC_W(8),  .IDX_W(4), .CNT_INIT(2'b01)) u_dut8  (.CLK(clk), .RST(rst), .bus(if8));

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus per instance.
  bit s_stall[2], s_redir[2], s_misp[2], s_updv[2], s_updt[2];
  int s_raddr[2], s_instr[2], s_updpc[2];

  // Model state per instance.
  int pcw[2]   = '{16, 8};
  int depth[2] = '{256, 16};
  int m_pc[2], m_lock[2], m_alt[2];
  bit m_boot[2], m_alt_ok[2];
  int m_cnt[2][256];
  bit m_valid = 1'b0;

  function automatic int mask(int k);
    return (1 << pcw[k]) - 1;
  endfunction

  function automatic int opc(int k);
    return (s_instr[k] >> 11) & 31;
  endfunction

  function automatic bit m_pred(int k);
    if (opc(k) == 2) return 1'b1;
    if (opc(k) == 4 || opc(k) == 5) return m_cnt[k][m_pc[k] % depth[k]] >= 2;
    return 1'b0;
  endfunction

  function automatic int m_seq(int k);
    return (m_pc[k] + 1) & mask(k);
  endfunction

  function automatic int m_tgt(int k);
    int v;
    if (opc(k) == 2) begin
      v = s_instr[k] & 'h7FF;
      if (v >= 'h400) v -= 'h800;
    end else begin
      v = s_instr[k] & 'hFF;
      if (v >= 'h80) v -= 'h100;
    end
    return (m_pc[k] + 1 + v) & mask(k);
  endfunction

  function automatic int m_epc(int k);
    return (s_redir[k] || s_misp[k]) ? m_lock[k] : m_pc[k];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_inst(int k, logic [31:0] pc, logic [31:0] pc1, logic [31:0] pr, logic [31:0] epc);
    check($sformatf("pc_o[%0d]", k), pc, 32'(m_pc[k]));
    check($sformatf("pcplus1_o[%0d]", k), pc1, 32'(m_seq(k)));
    check($sformatf("pred_taken_o[%0d]", k), pr, 32'(m_pred(k)));
    check($sformatf("epc_o[%0d]", k), epc, 32'(m_epc(k)));
  endtask

  task automatic apply();
    if16.stall_i = s_stall[0];  if16.redirect_i = s_redir[0];
    if16.redirect_addr_i = 16'(s_raddr[0]); if16.mispredict_i = s_misp[0];
    if16.instr_i = 16'(s_instr[0]); if16.upd_valid_i = s_updv[0];
    if16.upd_pc_i = 16'(s_updpc[0]); if16.upd_taken_i = s_updt[0];
    if8.stall_i = s_stall[1];   if8.redirect_i = s_redir[1];
    if8.redirect_addr_i = 8'(s_raddr[1]); if8.mispredict_i = s_misp[1];
    if8.instr_i = 16'(s_instr[1]); if8.upd_valid_i = s_updv[1];
    if8.upd_pc_i = 8'(s_updpc[1]); if8.upd_taken_i = s_updt[1];
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      s_stall[k] = 0; s_redir[k] = 0; s_misp[k] = 0; s_updv[k] = 0; s_updt[k] = 0;
      s_raddr[k] = 0; s_instr[k] = 0; s_updpc[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs held during that edge.
  task automatic model_update();
    int nxt, alt, idx;
    bit p, isbr;
    for (int k = 0; k < 2; k++) begin
      p    = m_pred(k);
      isbr = (opc(k) == 2) || (opc(k) == 4) || (opc(k) == 5);
      nxt  = s_redir[k] ? (s_raddr[k] & mask(k)) : s_misp[k] ? m_alt[k] : p ? m_tgt(k) : m_seq(k);
      alt  = p ? m_seq(k) : m_tgt(k);
      if (rst) begin
        m_pc[k] = 0; m_lock[k] = 0; m_alt[k] = 0; m_boot[k] = 1; m_alt_ok[k] = 1;
        for (int i = 0; i < 256; i++) m_cnt[k][i] = 1;
      end else begin
        if (!s_stall[k]) begin
          if (m_boot[k]) m_boot[k] = 0;
          else begin
            m_lock[k] = m_pc[k]; m_alt[k] = alt; m_alt_ok[k] = isbr; m_pc[k] = nxt;
          end
        end
        if (s_updv[k]) begin
          idx = s_updpc[k] % depth[k];
          if (s_updt[k]) m_cnt[k][idx] = (m_cnt[k][idx] == 3) ? 3 : m_cnt[k][idx] + 1;
          else           m_cnt[k][idx] = (m_cnt[k][idx] == 0) ? 0 : m_cnt[k][idx] - 1;
        end
      end
    end
    if (rst) m_valid = 1'b1;
  endtask

  task automatic settle();
    apply();
    #1;
  endtask

  // One clock: drive, compare both instances against the model, take the edge.
  task automatic step();
    settle();
    if (m_valid) begin
      chk_inst(0, 32'(if16.pc_o), 32'(if16.pcplus1_o), 32'(if16.pred_taken_o), 32'(if16.epc_o));
      chk_inst(1, 32'(if8.pc_o), 32'(if8.pcplus1_o), 32'(if8.pred_taken_o), 32'(if8.epc_o));
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic redirect_to(int k, int addr);
    idle(); s_redir[k] = 1; s_raddr[k] = addr; step(); idle();
  endtask

  int r;

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    step(); step();
    rst = 1'b0;

    // Reset and boot bubble: PC sequence 0,0,1,2,3 with NOPs.
    check("rst_pc", 32'(if16.pc_o), 0);
    step(); check("boot_pc", 32'(if16.pc_o), 0);
    step(); check("seq_pc1", 32'(if16.pc_o), 1);
    step(); check("seq_pc2", 32'(if16.pc_o), 2);
    step(); check("seq_pc3", 32'(if16.pc_o), 3);

    // Unconditional branch +5 at pc 3, then -1 at pc 0.
    s_instr[0] = 'h1005; settle(); check("B_pred", 32'(if16.pred_taken_o), 1);
    step(); check("B_tgt", 32'(if16.pc_o), 9);
    redirect_to(0, 0); check("redir0", 32'(if16.pc_o), 0);
    s_instr[0] = 'h17FF; settle(); check("Bm1_pred", 32'(if16.pred_taken_o), 1);
    step(); check("Bm1_tgt", 32'(if16.pc_o), 0);

    // Train entry 0x10 taken, fetch BEQZ -2.
    idle();
    for (int i = 0; i < 3; i++) begin s_updv[0] = 1; s_updpc[0] = 'h10; s_updt[0] = 1; step(); end
    redirect_to(0, 'h10);
    s_instr[0] = 'h20FE; settle(); check("beqz_trained_pred", 32'(if16.pred_taken_o), 1);
    step(); check("beqz_trained_tgt", 32'(if16.pc_o), 'h0F);
    idle(); s_updv[0] = 1; s_updpc[0] = 'h10; s_updt[0] = 1; step();
    s_updt[0] = 0;
    for (int i = 0; i < 4; i++) step();
    redirect_to(0, 'h10);
    s_instr[0] = 'h20FE; settle(); check("beqz_untrained_pred", 32'(if16.pred_taken_o), 0);
    step(); check("beqz_untrained_pc", 32'(if16.pc_o), 'h11);

    // Mispredict recovery for BNEZ +4 at 0x20.
    redirect_to(0, 'h20);
    s_instr[0] = 'h2804; settle(); check("bnez_pred", 32'(if16.pred_taken_o), 0);
    step(); check("bnez_seq", 32'(if16.pc_o), 'h21);
    idle(); s_misp[0] = 1; settle(); check("misp_epc", 32'(if16.epc_o), 'h20);
    step(); check("misp_pc", 32'(if16.pc_o), 'h25);

    // Redirect beats mispredict; stall holds PC while the BHT still updates.
    idle(); s_redir[0] = 1; s_raddr[0] = 'h100; s_misp[0] = 1; step();
    check("prio_pc", 32'(if16.pc_o), 'h100);
    idle(); s_stall[0] = 1; s_updv[0] = 1; s_updpc[0] = 'h100; s_updt[0] = 1; step();
    check("stall_pc", 32'(if16.pc_o), 'h100);
    idle(); s_instr[0] = 'h20FE; settle(); check("stall_upd_pred", 32'(if16.pred_taken_o), 1);
    step(); check("stall_upd_tgt", 32'(if16.pc_o), 'hFF);

    // Narrow instance: PC wrap and BHT aliasing.
    redirect_to(1, 'hFE); check("w8_fe", 32'(if8.pc_o), 'hFE);
    step(); check("w8_ff", 32'(if8.pc_o), 'hFF);
    step(); check("w8_wrap", 32'(if8.pc_o), 'h00);
    idle(); s_updv[1] = 1; s_updpc[1] = 'h13; s_updt[1] = 1; step();
    redirect_to(1, 'h03);
    s_instr[1] = 'h20FE; settle(); check("alias_pred_t", 32'(if8.pred_taken_o), 1);
    step();
    idle(); s_updv[1] = 1; s_updpc[1] = 'h03; s_updt[1] = 0; step(); step();
    redirect_to(1, 'h13);
    s_instr[1] = 'h20FE; settle(); check("alias_pred_nt", 32'(if8.pred_taken_o), 0);
    step();

    // Randomised traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 2; k++) begin
        s_stall[k] = ($urandom_range(0, 4) == 0);
        s_redir[k] = ($urandom_range(0, 9) == 0);
        s_raddr[k] = $urandom_range(0, 63);
        s_misp[k]  = m_alt_ok[k] && ($urandom_range(0, 5) == 0);
        r = $urandom_range(0, 4);
        case (r)
          0: s_instr[k] = (2 << 11) | $urandom_range(0, 2047);
          1: s_instr[k] = (4 << 11) | $urandom_range(0, 2047);
          2: s_instr[k] = (5 << 11) | $urandom_range(0, 2047);
          3: s_instr[k] = $urandom_range(0, 65535);
          default: s_instr[k] = 0;
        endcase
        s_updv[k]  = $urandom_range(0, 1);
        s_updpc[k] = $urandom_range(0, 1) ? m_pc[k] : $urandom_range(0, 300);
        s_updt[k]  = $urandom_range(0, 1);
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_bp.md
Name: ifetch_bp

Overview:
- Parametrised successor to the CPU's single-table fetch stage: holds the PC, decodes branch opcodes from the fetched instruction, predicts conditional branches with a BHT of 2-bit saturating counters, and chooses the next PC.
- Sits between instruction memory and the IF/ID register. Consumes redirect (JR), mispredict and BHT-update signals from the execute stage.
- New relative to the previous generation:
  - Parametrised PC width, table depth and counter reset value.
  - Only real branch opcodes are predicted.
  - BHT update carries its own PC.
  - Single posedge clock, with no negedge table writes.

Parameters:
PC_W, 16, PC and address width (8..32).
IDX_W, 8, BHT index width; depth = 2**IDX_W entries, indexed by pc[IDX_W-1:0].
CNT_INIT, 2'b01, counter value loaded into every entry on reset (weakly not-taken).

Ports:
CLK  in  1  clock; all state updates on rising edge.
RST  in  1  synchronous active-high reset.
stall_i  in  1  hold PC and lock registers when 1.
redirect_i  in  1  JR redirect from execute.
redirect_addr_i  in  PC_W  JR target.
mispredict_i  in  1  branch held in lock registers resolved opposite to its prediction.
instr_i  in  16  instruction at pc_o (combinational from IMEM).
upd_valid_i  in  1  BHT update strobe.
upd_pc_i  in  PC_W  PC of the resolved branch.
upd_taken_i  in  1  resolved direction.
pc_o  out  PC_W  current fetch PC.
pcplus1_o  out  PC_W  pc_o+1.
pred_taken_o  out  1  prediction for instr_i at pc_o (combinational).
epc_o  out  PC_W  exception PC: pc_lock when redirect_i or mispredict_i, else pc.

Behaviour:
- Reset (RST=1 at posedge):
  - pc, pc_lock and alt_lock are set to 0; boot flag is set to 1.
  - Every BHT entry is set to CNT_INIT.
  - RST overrides stall_i and all other inputs.
- Boot bubble: the first non-stalled edge after reset only clears boot; pc stays 0. This gives one extra cycle at PC 0.
- Branch decode from instr_i[15:11]:
  - 5'b00010 (B): unconditional; imm = sign-extended instr_i[10:0]; always taken; BHT not consulted.
  - 5'b00100 (BEQZ) and 5'b00101 (BNEZ): conditional; imm = sign-extended instr_i[7:0]; prediction = bht[pc[IDX_W-1:0]][1].
  - Any other opcode: not a branch; taken = 0.
- Targets: seq = pc+1; tgt = pc+1+sext(imm). Both are computed modulo 2**PC_W (wrap, no overflow flag).
- pred_taken_o = 1 for B, the counter MSB for BEQZ/BNEZ, and 0 otherwise.
- Next-PC priority: redirect_i → redirect_addr_i; else mispredict_i → alt_lock; else pred_taken_o ? tgt : seq.
- On every non-stalled, non-boot edge:
  - pc_lock <= pc.
  - alt_lock <= path not chosen (pred_taken_o ? seq : tgt).
  - pc <= next PC.
- stall_i=1: pc, pc_lock, alt_lock and boot hold. redirect_i and mispredict_i are ignored; execute re-asserts them after the stall.
- BHT update:
  - Applied at posedge when upd_valid_i=1, independent of stall_i, to entry upd_pc_i[IDX_W-1:0].
  - taken: increment, saturating at 2'b11. Not taken: decrement, saturating at 2'b00.
- Same-cycle read and write of one entry: pred_taken_o uses the pre-update value; the new value is visible from the next cycle.
- Aliasing: PCs with equal low IDX_W bits share one entry; this is accepted.
- No outputs are registered beyond pc; pcplus1_o, pred_taken_o and epc_o follow pc and instr_i combinationally.

Decomposition:
- Shared package ifetch_pkg holds:
  - Opcode constants OP_B=5'b00010, OP_BEQZ=5'b00100, OP_BNEZ=5'b00101.
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - The saturating increment/decrement function.
- One sub-module, bht_2bit (parameters IDX_W and CNT_INIT):
  - One asynchronous read port.
  - One synchronous update port.
  - Synchronous reset.

Test Plan:
- Reset and boot: RST=1 for 2 cycles then 0, with NOP at every PC → pc_o = 0,0,1,2 on successive edges after reset release; every BHT entry reads 2'b01.
- Unconditional branch: B with imm=+5 at pc=3 → pred_taken_o=1, next pc=9. B with imm=0x7FF (-1) at pc=0 → next pc=0.
- BHT training: 3 updates taken for upd_pc=0x0010, then fetch BEQZ (imm=-2) at 0x0010 → pred_taken_o=1, next pc=0x000F. A 4th taken update leaves the counter at 11. 4 not-taken updates reach 00 and the next fetch goes to 0x0011.
- Mispredict recovery: BNEZ at 0x0020 predicted not-taken (imm=+4); next cycle mispredict_i=1 → pc=0x0025 and epc_o=0x0020 during the mispredict cycle.
- Priority and stall: redirect_i=1 (addr 0x0100) together with mispredict_i=1 → pc=0x0100. With stall_i=1 and upd_valid_i=1 → pc holds and the counter still updates.
- Parameter sweep: PC_W=8, IDX_W=4 → pc wraps from 0xFF to 0x00 on sequential fetch; upd_pc 0x13 and 0x03 alias to the same entry.
